// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: state type, width helpers and rotating priority select shared by axis_pkt_arbiter
package axis_arb_pkg;

    typedef enum logic {IDLE, LOCK} state_t;

    localparam int MAX_SRC = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m) + 1;
    endfunction

    // First set bit of req at or above ptr, wrapping within the n active requesters.
    function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] g;
        int idx;
        g = ptr;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && req[idx[2:0]]) g = idx[2:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry registered AXI-Stream slice; in_ready comes straight from a flop
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; in_* upstream handshake
// and payload; out_* downstream handshake and payload (held stable while stalled).
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    assign in_ready = !skid_valid;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!out_valid || out_ready) begin
            out_data  <= in_data;
            out_valid <= in_valid;
        end else if (in_valid) begin
            // Beat accepted while output is stalled: park it in the second entry.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-atomic round-robin merge of NUM_SRC AXI-Stream sources into one registered output
// Ports: S_AXI_ACLK/S_AXI_ARESETN clock and async active-low reset; S_AXIS_* flattened per-source
// input streams; M_AXIS_* merged output stream; SRC_EN arbitration mask; GRANT_ID current/last grant;
// BUSY high while a packet is locked; LEN_ERR sticky forced-TLAST flags cleared by ERR_CLR.
// Optional macro AXIS_PKT_ARB_STATS_EN adds STATS_CLR and per-source 32-bit PKT_CNT packet counters.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BEATS  = 256
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [NUM_SRC-1:0]              S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]              S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]              S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0]         M_AXIS_TKEEP,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    input  logic [NUM_SRC-1:0]              SRC_EN,
    output logic [id_w(NUM_SRC)-1:0]        GRANT_ID,
    output logic                            BUSY,
    output logic [NUM_SRC-1:0]              LEN_ERR,
`ifdef AXIS_PKT_ARB_STATS_EN
    input  logic                            STATS_CLR,
    output logic [NUM_SRC*32-1:0]           PKT_CNT,
`endif
    input  logic                            ERR_CLR
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int IW = id_w(NUM_SRC);
    localparam int CW = cnt_w(MAX_BEATS);
    localparam int PW = DATA_WIDTH + KW + 1;

    state_t                state;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         pick;
    logic [CW-1:0]         beat_cnt;
    logic [MAX_SRC-1:0]    req;
    logic [DATA_WIDTH-1:0] g_data;
    logic [KW-1:0]         g_keep;
    logic                  g_valid;
    logic                  g_last;
    logic                  force_last;
    logic                  sb_ready;
    logic                  acc;

    always_comb begin
        req = '0;
        req[NUM_SRC-1:0] = S_AXIS_TVALID & SRC_EN;
        pick = IW'(rr_pick(req, 3'(rr_ptr), NUM_SRC));
    end

    assign g_data     = S_AXIS_TDATA[GRANT_ID*DATA_WIDTH +: DATA_WIDTH];
    assign g_keep     = S_AXIS_TKEEP[GRANT_ID*KW +: KW];
    assign g_valid    = (state == LOCK) && S_AXIS_TVALID[GRANT_ID];
    // Length limit: the MAX_BEATS-th beat closes the packet even without a source TLAST.
    assign force_last = !S_AXIS_TLAST[GRANT_ID] && beat_cnt == CW'(MAX_BEATS - 1);
    assign g_last     = S_AXIS_TLAST[GRANT_ID] || force_last;
    assign acc        = g_valid && sb_ready;
    assign BUSY       = (state == LOCK);

    assign S_AXIS_TREADY = (state == LOCK && sb_ready) ? NUM_SRC'(1) << GRANT_ID : '0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state    <= IDLE;
            GRANT_ID <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            LEN_ERR  <= '0;
        end else begin
            // A forced TLAST in the same cycle as ERR_CLR keeps its flag set.
            LEN_ERR <= (LEN_ERR & ~{NUM_SRC{ERR_CLR}}) | ((acc && force_last) ? NUM_SRC'(1) << GRANT_ID : '0);
            if (state == IDLE) begin
                beat_cnt <= '0;
                if (|req) begin
                    GRANT_ID <= pick;
                    rr_ptr   <= (pick == IW'(NUM_SRC - 1)) ? '0 : pick + 1'b1;
                    state    <= LOCK;
                end
            end else if (acc) begin
                beat_cnt <= g_last ? '0 : beat_cnt + 1'b1;
                if (g_last) state <= IDLE;
            end
        end
    end

    axis_skid_buffer #(.WIDTH(PW)) u_skid (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .in_data       ({g_last, g_keep, g_data}),
        .in_valid      (g_valid),
        .in_ready      (sb_ready),
        .out_data      ({M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA}),
        .out_valid     (M_AXIS_TVALID),
        .out_ready     (M_AXIS_TREADY)
    );

`ifdef AXIS_PKT_ARB_STATS_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            PKT_CNT <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (STATS_CLR)
                    PKT_CNT[i*32 +: 32] <= '0;
                else if (acc && g_last && GRANT_ID == IW'(i))
                    PKT_CNT[i*32 +: 32] <= PKT_CNT[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule
